// File: rtl/xfcp_arb.sv
// xfcp_arb: grants one upstream XFCP request packet at a time to the downstream
// port and routes the matching reply back to the same upstream port.
// Latency: 1 cycle from any accepted input beat to output valid (registered
// skid buffers on every output). Backpressure: readies are registered and drop
// only when a skid entry holds a stalled beat, so throughput is 1 beat/cycle.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   up_xfcp_in_*   [PORTS]   upstream request streams (tdata packed 8 bits/port)
//   up_xfcp_out_*  [PORTS]   upstream response streams
//   down_xfcp_in_*           downstream response stream
//   down_xfcp_out_*          downstream request stream

// Two-entry register slice: an output register plus one skid entry.
module xfcp_arb_skid #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] i_dat,
  input  logic         i_vld,
  output logic         o_rdy,
  output logic [W-1:0] o_dat,
  output logic         o_vld,
  input  logic         i_rdy
);
  logic [W-1:0] r_out_dat;
  logic [W-1:0] r_skid_dat;
  logic         r_out_vld;
  logic         r_skid_vld;
  logic         r_in_rdy;
  logic         w_in_xfer;
  logic         w_out_load;
  logic         w_skid_nxt;

  assign w_in_xfer  = i_vld && r_in_rdy;
  assign w_out_load = !r_out_vld || i_rdy;
  // The skid entry fills only when a beat lands while the output is stalled;
  // it drains into the output register as soon as the output moves.
  assign w_skid_nxt = !w_out_load && (r_skid_vld || w_in_xfer);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_dat  <= '0;
      r_skid_dat <= '0;
      r_out_vld  <= 1'b0;
      r_skid_vld <= 1'b0;
      r_in_rdy   <= 1'b0;
    end else begin
      r_skid_vld <= w_skid_nxt;
      r_in_rdy   <= !w_skid_nxt;
      if (w_out_load) begin
        if (r_skid_vld) begin
          r_out_vld <= 1'b1;
          r_out_dat <= r_skid_dat;
        end else begin
          r_out_vld <= w_in_xfer;
          if (w_in_xfer) r_out_dat <= i_dat;
        end
      end else if (w_in_xfer) begin
        r_skid_dat <= i_dat;
      end
    end
  end

  assign o_rdy = r_in_rdy;
  assign o_dat = r_out_dat;
  assign o_vld = r_out_vld;
endmodule

module xfcp_arb #(
  parameter int PORTS = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [PORTS*8-1:0] up_xfcp_in_tdata,
  input  logic [PORTS-1:0]   up_xfcp_in_tvalid,
  output logic [PORTS-1:0]   up_xfcp_in_tready,
  input  logic [PORTS-1:0]   up_xfcp_in_tlast,
  input  logic [PORTS-1:0]   up_xfcp_in_tuser,
  output logic [PORTS*8-1:0] up_xfcp_out_tdata,
  output logic [PORTS-1:0]   up_xfcp_out_tvalid,
  input  logic [PORTS-1:0]   up_xfcp_out_tready,
  output logic [PORTS-1:0]   up_xfcp_out_tlast,
  output logic [PORTS-1:0]   up_xfcp_out_tuser,
  input  logic [7:0]         down_xfcp_in_tdata,
  input  logic               down_xfcp_in_tvalid,
  output logic               down_xfcp_in_tready,
  input  logic               down_xfcp_in_tlast,
  input  logic               down_xfcp_in_tuser,
  output logic [7:0]         down_xfcp_out_tdata,
  output logic               down_xfcp_out_tvalid,
  input  logic               down_xfcp_out_tready,
  output logic               down_xfcp_out_tlast,
  output logic               down_xfcp_out_tuser
);
  localparam int GW = (PORTS > 1) ? $clog2(PORTS) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [GW-1:0]    r_grant;
  logic [GW-1:0]    w_grant_nxt;
  logic [GW-1:0]    r_ptr;
  logic [GW-1:0]    w_ptr_nxt;
  logic [GW-1:0]    w_pick;
  logic             w_found;

  logic             w_req_vld;
  logic [9:0]       w_req_dat;
  logic             w_down_rdy;
  logic             w_down_xfer;
  logic [9:0]       w_down_dat;
  logic [PORTS-1:0] w_up_rdy;
  logic             w_resp_xfer;

  // ---------------- request path: granted port -> downstream ----------------
  assign w_req_vld   = (r_state == ST_REQ) && up_xfcp_in_tvalid[r_grant];
  assign w_req_dat   = {up_xfcp_in_tdata[r_grant*8 +: 8],
                        up_xfcp_in_tlast[r_grant], up_xfcp_in_tuser[r_grant]};
  assign w_down_xfer = w_req_vld && w_down_rdy;

  always_comb begin
    up_xfcp_in_tready = '0;
    if (r_state == ST_REQ) up_xfcp_in_tready[r_grant] = w_down_rdy;
  end

  xfcp_arb_skid #(.W(10)) u_down_skid (
    .clk   (clk),
    .rst   (rst),
    .i_dat (w_req_dat),
    .i_vld (w_req_vld),
    .o_rdy (w_down_rdy),
    .o_dat (w_down_dat),
    .o_vld (down_xfcp_out_tvalid),
    .i_rdy (down_xfcp_out_tready)
  );

  assign down_xfcp_out_tdata = w_down_dat[9:2];
  assign down_xfcp_out_tlast = w_down_dat[1];
  assign down_xfcp_out_tuser = w_down_dat[0];

  // ---------------- response path: downstream -> granted port --------------
  // Outside RESP the downstream reply is held off rather than dropped.
  assign down_xfcp_in_tready = (r_state == ST_RESP) && w_up_rdy[r_grant];
  assign w_resp_xfer         = down_xfcp_in_tvalid && down_xfcp_in_tready;

  for (genvar n = 0; n < PORTS; n++) begin : g_up
    logic       w_vld;
    logic [9:0] w_dat;

    assign w_vld = (r_state == ST_RESP) && (r_grant == GW'(n)) && down_xfcp_in_tvalid;

    xfcp_arb_skid #(.W(10)) u_skid (
      .clk   (clk),
      .rst   (rst),
      .i_dat ({down_xfcp_in_tdata, down_xfcp_in_tlast, down_xfcp_in_tuser}),
      .i_vld (w_vld),
      .o_rdy (w_up_rdy[n]),
      .o_dat (w_dat),
      .o_vld (up_xfcp_out_tvalid[n]),
      .i_rdy (up_xfcp_out_tready[n])
    );

    assign up_xfcp_out_tdata[n*8 +: 8] = w_dat[9:2];
    assign up_xfcp_out_tlast[n]        = w_dat[1];
    assign up_xfcp_out_tuser[n]        = w_dat[0];
  end

  // ---------------- round-robin pick: first requester at/after r_ptr --------
  always_comb begin
    int            j;
    logic [GW-1:0] idx;
    j       = 0;
    idx     = '0;
    w_found = 1'b0;
    w_pick  = '0;
    for (int i = 0; i < PORTS; i++) begin
      j = int'(r_ptr) + i;
      if (j >= PORTS) j = j - PORTS;
      idx = GW'(j);
      if (!w_found && up_xfcp_in_tvalid[idx]) begin
        w_found = 1'b1;
        w_pick  = idx;
      end
    end
  end

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_grant <= '0;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_ptr_nxt   = r_ptr;
    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_grant_nxt = w_pick;
          w_state_nxt = ST_REQ;
        end
      end
      ST_REQ: begin
        // A bad frame is discarded downstream without a reply, so there is
        // nothing to wait for.
        if (w_down_xfer && up_xfcp_in_tlast[r_grant]) begin
          w_state_nxt = up_xfcp_in_tuser[r_grant] ? ST_IDLE : ST_RESP;
        end
      end
      ST_RESP: begin
        if (w_resp_xfer && down_xfcp_in_tlast) begin
          w_state_nxt = ST_IDLE;
          w_ptr_nxt   = (r_grant == GW'(PORTS - 1)) ? '0 : r_grant + 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end
endmodule

// File: tb/tb_xfcp_arb.sv
module tb_xfcp_arb;
  localparam int P = 2;

  typedef struct packed {
    logic [7:0] d;
    logic       l;
    logic       u;
  } beat_t;

  typedef struct {
    int         port;
    logic [7:0] base;
    int         len;
    bit         bad;
    logic [7:0] rbase;
    int         rlen;
    int         budget;
    int         exp_rx0;
    int         exp_rx1;
  } vec_t;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [P*8-1:0] up_in_tdata;
  logic [P-1:0]   up_in_tvalid, up_in_tready, up_in_tlast, up_in_tuser;
  logic [P*8-1:0] up_out_tdata;
  logic [P-1:0]   up_out_tvalid, up_out_tready, up_out_tlast, up_out_tuser;
  logic [7:0]     dn_in_tdata;
  logic           dn_in_tvalid, dn_in_tready, dn_in_tlast, dn_in_tuser;
  logic [7:0]     dn_out_tdata;
  logic           dn_out_tvalid, dn_out_tready, dn_out_tlast, dn_out_tuser;

  int tests = 0;
  int fails = 0;

  beat_t src_q0[$];
  beat_t src_q1[$];
  beat_t rsp_q[$];
  beat_t exp_down[$];
  beat_t exp_up0[$];
  beat_t exp_up1[$];

  bit    src_pend0, src_pend1, rsp_pend, outstanding;
  bit    dn_stall;
  beat_t dn_sd;
  bit    up_stall [P];
  beat_t up_sd [P];
  int    rx_up [P];
  bit    bp = 1'b0;
  int    cyc = 0;

  xfcp_arb #(.PORTS(P)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .up_xfcp_in_tdata     (up_in_tdata),
    .up_xfcp_in_tvalid    (up_in_tvalid),
    .up_xfcp_in_tready    (up_in_tready),
    .up_xfcp_in_tlast     (up_in_tlast),
    .up_xfcp_in_tuser     (up_in_tuser),
    .up_xfcp_out_tdata    (up_out_tdata),
    .up_xfcp_out_tvalid   (up_out_tvalid),
    .up_xfcp_out_tready   (up_out_tready),
    .up_xfcp_out_tlast    (up_out_tlast),
    .up_xfcp_out_tuser    (up_out_tuser),
    .down_xfcp_in_tdata   (dn_in_tdata),
    .down_xfcp_in_tvalid  (dn_in_tvalid),
    .down_xfcp_in_tready  (dn_in_tready),
    .down_xfcp_in_tlast   (dn_in_tlast),
    .down_xfcp_in_tuser   (dn_in_tuser),
    .down_xfcp_out_tdata  (dn_out_tdata),
    .down_xfcp_out_tvalid (dn_out_tvalid),
    .down_xfcp_out_tready (dn_out_tready),
    .down_xfcp_out_tlast  (dn_out_tlast),
    .down_xfcp_out_tuser  (dn_out_tuser)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Queue one transaction in expected service order: request beats go to the
  // source and the downstream scoreboard; the reply (none for a bad frame) goes
  // to the downstream responder and the upstream scoreboard of that port.
  task automatic txn(input int port, input logic [7:0] base, input int len, input bit bad,
                     input logic [7:0] rbase, input int rlen);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.d = base + 8'(i);
      b.l = (i == len - 1);
      b.u = bad && (i == len - 1);
      if (port == 0) src_q0.push_back(b);
      else src_q1.push_back(b);
      exp_down.push_back(b);
    end
    if (!bad) begin
      for (int i = 0; i < rlen; i++) begin
        b.d = rbase + 8'(i * 17);
        b.l = (i == rlen - 1);
        b.u = 1'b0;
        rsp_q.push_back(b);
        if (port == 0) exp_up0.push_back(b);
        else exp_up1.push_back(b);
      end
    end
  endtask

  task automatic mon_down();
    beat_t act;
    beat_t e;
    act = {dn_out_tdata, dn_out_tlast, dn_out_tuser};
    if (dn_stall) begin
      chk("down_stall_vld", 32'(dn_out_tvalid), 32'd1);
      chk("down_stall_dat", 32'(act), 32'(dn_sd));
    end
    dn_stall = 1'b0;
    if (dn_out_tvalid) begin
      if (dn_out_tready) begin
        if (exp_down.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL down_unexpected: got %h, expected no beat", act);
        end else begin
          e = exp_down.pop_front();
          chk("down_beat", 32'(act), 32'(e));
          chk("down_no_interleave", 32'(outstanding), 32'd0);
          if (e.l && !e.u) outstanding = 1'b1;
        end
      end else begin
        dn_stall = 1'b1;
        dn_sd    = act;
      end
    end
  endtask

  task automatic mon_up(input int p);
    beat_t act;
    beat_t e;
    act = {up_out_tdata[p*8 +: 8], up_out_tlast[p], up_out_tuser[p]};
    if (up_stall[p]) begin
      chk($sformatf("up%0d_stall_vld", p), 32'(up_out_tvalid[p]), 32'd1);
      chk($sformatf("up%0d_stall_dat", p), 32'(act), 32'(up_sd[p]));
    end
    up_stall[p] = 1'b0;
    if (up_out_tvalid[p]) begin
      if (up_out_tready[p]) begin
        rx_up[p]++;
        if ((p == 0 && exp_up0.size() == 0) || (p == 1 && exp_up1.size() == 0)) begin
          tests++;
          fails++;
          $display("FAIL up%0d_unexpected: got %h, expected no beat", p, act);
        end else begin
          e = (p == 0) ? exp_up0.pop_front() : exp_up1.pop_front();
          chk($sformatf("up%0d_beat", p), 32'(act), 32'(e));
        end
      end else begin
        up_stall[p] = 1'b1;
        up_sd[p]    = act;
      end
    end
  endtask

  // Per-cycle engine: retire last edge's transfers, drive sinks/sources for
  // the coming edge, then score what the DUT presents.
  initial begin : engine
    beat_t b;
    forever begin
      @(negedge clk);
      #1;
      cyc++;
      if (rst) begin
        up_in_tvalid = '0;
        dn_in_tvalid = 1'b0;
        dn_stall     = 1'b0;
        up_stall[0]  = 1'b0;
        up_stall[1]  = 1'b0;
      end else begin
        if (src_pend0) begin b = src_q0.pop_front(); src_pend0 = 1'b0; end
        if (src_pend1) begin b = src_q1.pop_front(); src_pend1 = 1'b0; end
        if (rsp_pend) begin
          b = rsp_q.pop_front();
          if (b.l) outstanding = 1'b0;
          rsp_pend = 1'b0;
        end
        dn_out_tready    = !bp || cyc[0];
        up_out_tready[0] = 1'b1;
        up_out_tready[1] = !bp || !cyc[0];
        if (src_q0.size() > 0) begin
          b = src_q0[0];
          up_in_tdata[7:0] = b.d; up_in_tlast[0] = b.l; up_in_tuser[0] = b.u; up_in_tvalid[0] = 1'b1;
        end else up_in_tvalid[0] = 1'b0;
        if (src_q1.size() > 0) begin
          b = src_q1[0];
          up_in_tdata[15:8] = b.d; up_in_tlast[1] = b.l; up_in_tuser[1] = b.u; up_in_tvalid[1] = 1'b1;
        end else up_in_tvalid[1] = 1'b0;
        if (rsp_q.size() > 0) begin
          b = rsp_q[0];
          dn_in_tdata = b.d; dn_in_tlast = b.l; dn_in_tuser = b.u; dn_in_tvalid = 1'b1;
        end else dn_in_tvalid = 1'b0;
        src_pend0 = up_in_tvalid[0] && up_in_tready[0];
        src_pend1 = up_in_tvalid[1] && up_in_tready[1];
        rsp_pend  = dn_in_tvalid && dn_in_tready;
        mon_down();
        mon_up(0);
        mon_up(1);
      end
    end
  end

  function automatic bit idle();
    return src_q0.size() == 0 && src_q1.size() == 0 && rsp_q.size() == 0 &&
           exp_down.size() == 0 && exp_up0.size() == 0 && exp_up1.size() == 0 &&
           !src_pend0 && !src_pend1 && !rsp_pend && !dn_out_tvalid && up_out_tvalid == '0;
  endfunction

  task automatic wait_drain(input int budget, input string nm);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #2;
      if (idle()) begin ok = 1'b1; break; end
    end
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s_timeout: got pending traffic after %0d cycles, expected drained", nm, budget);
    end
  endtask

  task automatic do_reset(input string nm);
    @(negedge clk);
    rst = 1'b1;
    src_q0.delete(); src_q1.delete(); rsp_q.delete();
    exp_down.delete(); exp_up0.delete(); exp_up1.delete();
    src_pend0 = 1'b0; src_pend1 = 1'b0; rsp_pend = 1'b0; outstanding = 1'b0;
    @(negedge clk);
    #2;
    chk({nm, "_down_out_vld"}, 32'(dn_out_tvalid), 32'd0);
    chk({nm, "_up_out_vld"},   32'(up_out_tvalid), 32'd0);
    chk({nm, "_up_in_rdy"},    32'(up_in_tready), 32'd0);
    chk({nm, "_down_in_rdy"},  32'(dn_in_tready), 32'd0);
    chk({nm, "_down_out_dat"}, 32'({dn_out_tdata, dn_out_tlast, dn_out_tuser}), 32'd0);
    chk({nm, "_up_out_dat"},   32'({up_out_tdata, up_out_tlast, up_out_tuser}), 32'd0);
    rst = 1'b0;
  endtask

  initial begin : watchdog
    #300000;
    fails++;
    $display("FAIL watchdog: simulation still running at time limit, expected completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog expired");
  end

  initial begin : test
    vec_t vt[5];
    int   r0, r1;
    bit   seen;

    up_in_tdata = '0; up_in_tvalid = '0; up_in_tlast = '0; up_in_tuser = '0;
    dn_in_tdata = '0; dn_in_tvalid = 1'b0; dn_in_tlast = 1'b0; dn_in_tuser = 1'b0;
    dn_out_tready = 1'b1; up_out_tready = '1;
    rx_up[0] = 0; rx_up[1] = 0;

    //         port base   len bad rbase  rlen budget rx0 rx1
    vt[0] = '{0, 8'h01, 3, 0, 8'hAA, 2, 40, 2, 0};
    vt[1] = '{1, 8'h10, 4, 0, 8'h40, 3, 40, 0, 3};
    vt[2] = '{1, 8'h20, 2, 1, 8'h00, 0, 40, 0, 0};
    vt[3] = '{0, 8'h30, 1, 0, 8'h50, 1, 10, 1, 0};
    vt[4] = '{0, 8'h60, 5, 0, 8'h70, 4, 40, 4, 0};

    repeat (2) @(negedge clk);
    do_reset("rst0");

    for (int i = 0; i < 5; i++) begin
      r0 = rx_up[0];
      r1 = rx_up[1];
      txn(vt[i].port, vt[i].base, vt[i].len, vt[i].bad, vt[i].rbase, vt[i].rlen);
      wait_drain(vt[i].budget, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d_rx0", i), 32'(rx_up[0] - r0), 32'(vt[i].exp_rx0));
      chk($sformatf("vec%0d_rx1", i), 32'(rx_up[1] - r1), 32'(vt[i].exp_rx1));
    end

    // Simultaneous requests from a fresh pointer: port 0 then port 1.
    do_reset("rst1");
    txn(0, 8'hA0, 4, 0, 8'hB0, 2);
    txn(1, 8'hC0, 4, 0, 8'hD0, 2);
    wait_drain(80, "simul");

    // Port 0 keeps requesting, port 1 has one pending: 0,1,0,0.
    txn(0, 8'h00, 3, 0, 8'h11, 1);
    txn(1, 8'h40, 3, 0, 8'h22, 2);
    txn(0, 8'h80, 3, 0, 8'h33, 1);
    txn(0, 8'hC8, 2, 0, 8'h44, 1);
    wait_drain(150, "rrobin");

    // Alternating backpressure on both sinks during a port 1 transaction.
    r1 = rx_up[1];
    bp = 1'b1;
    txn(1, 8'h80, 6, 0, 8'h90, 5);
    wait_drain(200, "bp");
    bp = 1'b0;
    chk("bp_rx1", 32'(rx_up[1] - r1), 32'd5);

    // Reset in the middle of a request packet, then a clean port 1 request.
    txn(0, 8'hE0, 8, 0, 8'hF0, 2);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      #2;
      if (dn_out_tvalid) begin seen = 1'b1; break; end
    end
    chk("midreq_reached", 32'(seen), 32'd1);
    do_reset("rst2");
    r1 = rx_up[1];
    txn(1, 8'h51, 3, 0, 8'h61, 2);
    wait_drain(60, "post_rst");
    chk("post_rst_rx1", 32'(rx_up[1] - r1), 32'd2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
